// File: rtl/rom_line_fetcher.sv
// rom_line_fetcher: refills one instruction-cache line from a word-addressed
// backing memory after a core miss, then presents the assembled line for a
// single cycle.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-high reset
//   rom_re     - level refill request from the core
//   rom_addr   - byte address of the missed instruction
//   mem_rd     - backing-memory read request, held until mem_ack
//   mem_addr   - backing-memory word index ((byte address - BASE_ADDR) >> 2)
//   mem_ack    - mem_rdata valid this cycle
//   mem_rdata  - backing-memory read data
//   rom_out    - assembled line; element i is the word at line_base + 4*i
//   rom_oe     - one-cycle pulse: rom_out holds the complete requested line
//   busy       - high whenever a refill is in progress (not IDLE)
module rom_line_fetcher #(
    parameter int unsigned LINE_WORDS_LOG2 = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_re,
    input  logic [31:0] rom_addr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rom_out [1 << LINE_WORDS_LOG2],
    output logic        rom_oe,
    output logic        busy
);

    localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG2;
    localparam int unsigned CNT_W      = (LINE_WORDS_LOG2 > 0) ? LINE_WORDS_LOG2 : 1;
    localparam int unsigned OFF_BITS   = LINE_WORDS_LOG2 + 2;
    localparam logic [31:0] OFF_MASK   = (32'd1 << OFF_BITS) - 32'd1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        COOL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       base_q, base_d;
    logic              wr_en_c;
    logic [31:0]       next_addr_c;

    // Next-state logic: latch the line on request, count acked words, then
    // spend one DONE cycle (pulse) and one COOL cycle (request ignored).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wr_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (rom_re) begin
                    base_d  = rom_addr & ~OFF_MASK;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    wr_en_c = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = COOL;
            default: state_d = IDLE;
        endcase
    end

    // Word index of the next word to request; only meaningful while the
    // next state is FETCH, and unchanged across wait cycles.
    always_comb begin
        next_addr_c = ((base_d - BASE_ADDR) >> 2) + 32'(cnt_d);
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Outputs registered from the next state so they line up with the state
    // they describe, without a combinational path to the ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rom_oe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mem_rd <= (state_d == FETCH);
            rom_oe <= (state_d == DONE);
            busy   <= (state_d != IDLE);
            if (state_d == FETCH) begin
                mem_addr <= next_addr_c;
            end
        end
    end

    // Line storage: one register per word, written only by an ack in FETCH.
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_word
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rom_out[g] <= '0;
            end else if (wr_en_c && (cnt_q == CNT_W'(g))) begin
                rom_out[g] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rom_line_fetcher.sv
module tb_rom_line_fetcher;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        reset;

    // Default-parameter instance (4-word lines)
    logic        rom_re;
    logic [31:0] rom_addr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] rom_out [4];
    logic        rom_oe;
    logic        busy;

    // Single-word-line instance
    logic        b_rom_re;
    logic [31:0] b_rom_addr;
    logic        b_mem_rd;
    logic [31:0] b_mem_addr;
    logic        b_mem_ack;
    logic [31:0] b_mem_rdata;
    logic [31:0] b_rom_out [1];
    logic        b_rom_oe;
    logic        b_busy;

    int total;
    int bad;

    rom_line_fetcher dut (
        .clk(clk), .reset(reset), .rom_re(rom_re), .rom_addr(rom_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rom_out(rom_out), .rom_oe(rom_oe), .busy(busy)
    );

    rom_line_fetcher #(.LINE_WORDS_LOG2(0)) dut_w1 (
        .clk(clk), .reset(reset), .rom_re(b_rom_re), .rom_addr(b_rom_addr),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack),
        .mem_rdata(b_mem_rdata), .rom_out(b_rom_out), .rom_oe(b_rom_oe), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing-memory contents as a function of word index.
    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return idx * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    // One full refill of the 4-word instance. Entered and left at a negedge
    // in IDLE. hold keeps rom_re high throughout; perturb scrambles rom_re and
    // rom_addr while the line is in flight.
    task automatic refill(input logic [31:0] addr, input int min_w, input int max_w,
                          input bit hold, input bit perturb);
        logic [31:0] idx0;
        int words;
        int wait_left;
        int cycles;
        idx0 = ((addr & ~32'hF) - BASE) >> 2;
        rom_re   = 1'b1;
        rom_addr = addr;
        @(negedge clk);
        words = 0;
        cycles = 0;
        wait_left = $urandom_range(max_w, min_w);
        while (words < 4 && cycles < 100) begin
            if (perturb) begin
                rom_addr = 32'h8000_0100;
                rom_re   = 1'($urandom);
            end else begin
                rom_re = hold;
            end
            total++;
            if (mem_rd !== 1'b1 || busy !== 1'b1 || rom_oe !== 1'b0) begin
                bad++;
                $display("FAIL fetch_ctrl addr=%h word=%0d: rd=%b busy=%b oe=%b, want 1 1 0",
                         addr, words, mem_rd, busy, rom_oe);
            end
            total++;
            if (mem_addr !== idx0 + 32'(words)) begin
                bad++;
                $display("FAIL fetch_addr addr=%h word=%0d: got %h want %h",
                         addr, words, mem_addr, idx0 + 32'(words));
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(idx0 + 32'(words));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wait_left--;
            end
            @(negedge clk);
            cycles++;
            if (mem_ack) begin
                words++;
                wait_left = $urandom_range(max_w, min_w);
            end
        end
        total++;
        if (words < 4) begin
            bad++;
            $display("FAIL fetch_timeout addr=%h: got %0d words want 4", addr, words);
        end
        // DONE cycle: acks here must be ignored.
        rom_re    = hold;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        total++;
        if (rom_oe !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_ctrl addr=%h: oe=%b rd=%b busy=%b, want 1 0 1",
                     addr, rom_oe, mem_rd, busy);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rom_out[i] !== mem_word(idx0 + 32'(i))) begin
                bad++;
                $display("FAIL line_data addr=%h [%0d]: got %h want %h",
                         addr, i, rom_out[i], mem_word(idx0 + 32'(i)));
            end
        end
        @(negedge clk);
        // COOL cycle.
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        total++;
        if (rom_oe !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL cool_ctrl addr=%h: oe=%b rd=%b busy=%b, want 0 0 1",
                     addr, rom_oe, mem_rd, busy);
        end
        @(negedge clk);
        // Back in IDLE; line must still hold despite stray acks.
        mem_ack = 1'b0;
        total++;
        if (rom_oe !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_ctrl addr=%h: oe=%b rd=%b busy=%b, want 0 0 0",
                     addr, rom_oe, mem_rd, busy);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rom_out[i] !== mem_word(idx0 + 32'(i))) begin
                bad++;
                $display("FAIL line_hold addr=%h [%0d]: got %h want %h",
                         addr, i, rom_out[i], mem_word(idx0 + 32'(i)));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (mem_rd !== 1'b0 || rom_oe !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL reset_ctrl: rd=%b oe=%b busy=%b addr=%h, want 0 0 0 0",
                     mem_rd, rom_oe, busy, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rom_out[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_line[%0d]: got %h want 0", i, rom_out[i]);
            end
        end
        total++;
        if (b_mem_rd !== 1'b0 || b_busy !== 1'b0 || b_rom_out[0] !== 32'd0) begin
            bad++;
            $display("FAIL reset_w1: rd=%b busy=%b out=%h, want 0 0 0",
                     b_mem_rd, b_busy, b_rom_out[0]);
        end
        // First request is accepted on the first edge after release.
        reset = 1'b0;
        refill(32'h8000_0014, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        refill(32'h8000_0014, 0, 0, 1'b0, 1'b0);
        refill(32'h8000_0020, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wait_states();
        refill(32'h8000_0014, 3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        refill(32'h8000_0014, 0, 0, 1'b1, 1'b0);
        refill(32'h8000_0040, 0, 1, 1'b1, 1'b0);
        refill(32'h8000_007C, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_addr_change();
        refill(32'h8000_0014, 0, 2, 1'b0, 1'b1);
        rom_re = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        rom_re   = 1'b1;
        rom_addr = 32'h8000_0014;
        @(negedge clk);
        rom_re = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(32'(4 + i));
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mem_rd !== 1'b0 || rom_oe !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL async_reset_ctrl: rd=%b oe=%b busy=%b addr=%h, want 0 0 0 0",
                     mem_rd, rom_oe, busy, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rom_out[i] !== 32'd0) begin
                bad++;
                $display("FAIL async_reset_line[%0d]: got %h want 0", i, rom_out[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        // Stray acks after release must not revive the aborted line.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (mem_rd !== 1'b0 || rom_oe !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle cyc=%0d: rd=%b oe=%b busy=%b, want 0 0 0",
                         i, mem_rd, rom_oe, busy);
            end
        end
        mem_ack = 1'b0;
        refill(32'h8000_0014, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_single_word_line();
        b_rom_re   = 1'b1;
        b_rom_addr = 32'h8000_0008;
        @(negedge clk);
        b_rom_re = 1'b0;
        total++;
        if (b_mem_rd !== 1'b1 || b_mem_addr !== 32'd2 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL w1_fetch: rd=%b addr=%h busy=%b, want 1 2 1",
                     b_mem_rd, b_mem_addr, b_busy);
        end
        b_mem_ack   = 1'b1;
        b_mem_rdata = mem_word(32'd2);
        @(negedge clk);
        b_mem_ack = 1'b0;
        total++;
        if (b_rom_oe !== 1'b1 || b_mem_rd !== 1'b0 || b_rom_out[0] !== mem_word(32'd2)) begin
            bad++;
            $display("FAIL w1_done: oe=%b rd=%b out=%h, want 1 0 %h",
                     b_rom_oe, b_mem_rd, b_rom_out[0], mem_word(32'd2));
        end
        @(negedge clk);
        total++;
        if (b_rom_oe !== 1'b0 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL w1_cool: oe=%b busy=%b, want 0 1", b_rom_oe, b_busy);
        end
        @(negedge clk);
        total++;
        if (b_busy !== 1'b0) begin
            bad++;
            $display("FAIL w1_idle: busy=%b want 0", b_busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [31:0] a;
            bit hold;
            a    = BASE | ($urandom & 32'h0FFF_FFFF);
            hold = (n != 9) ? 1'($urandom) : 1'b0;
            refill(a, 0, 3, hold, 1'($urandom));
        end
        rom_re = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        rom_re      = 1'b0;
        rom_addr    = 32'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        b_rom_re    = 1'b0;
        b_rom_addr  = 32'd0;
        b_mem_ack   = 1'b0;
        b_mem_rdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wait_states();
        test_back_to_back();
        test_addr_change();
        test_reset_mid_fetch();
        test_single_word_line();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_line_fetcher.md
ROM_LINE_FETCHER -- requirements
Module: rom_line_fetcher

Interface
REQ-001 Parameter LINE_WORDS_LOG2, default 2, log2 of 32-bit words per cache line (line = 2**LINE_WORDS_LOG2 words).
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, byte address mapped to backing-memory word 0.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rom_re  input  1  level refill request from core (cache miss).
REQ-006 rom_addr  input  32  byte address of missed instruction.
REQ-007 mem_rd  output  1  backing-memory read request, held until mem_ack.
REQ-008 mem_addr  output  32  backing-memory word index: (byte address - BASE_ADDR) >> 2.
REQ-009 mem_ack  input  1  read data valid on mem_rdata this cycle.
REQ-010 mem_rdata  input  32  backing-memory read data.
REQ-011 rom_out  output  32 x 2**LINE_WORDS_LOG2  assembled line, element i = word at line_base + 4*i.
REQ-012 rom_oe  output  1  one-cycle pulse: rom_out holds a complete line for the latched address.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, FETCH, DONE, COOL.
REQ-015 IDLE: if rom_re=1, latch line_base = rom_addr with bits [LINE_WORDS_LOG2+1:0] cleared, clear word counter, go FETCH next cycle.
REQ-016 FETCH: mem_rd=1, mem_addr for line_base + 4*counter; mem_addr SHALL stay stable while mem_rd=1 and mem_ack=0.
REQ-017 On mem_ack=1 in FETCH: store mem_rdata into rom_out[counter]; if counter = last index go DONE, else counter+1 and mem_rd stays high (back-to-back requests allowed, one word per acked cycle).
REQ-018 mem_ack while not in FETCH SHALL be ignored.
REQ-019 DONE: rom_oe=1 for exactly one cycle, mem_rd=0, go COOL.
REQ-020 COOL: rom_oe=0, rom_re ignored for this one cycle (covers core's hit-update latency), go IDLE.
REQ-021 rom_addr/rom_re changes during FETCH/DONE/COOL SHALL NOT affect the line in flight.
REQ-022 rom_re dropping during FETCH SHALL NOT abort; line completes and rom_oe still pulses.
REQ-023 Counter SHALL be LINE_WORDS_LOG2 bits (min 1) and never wrap within one line.
REQ-024 rom_out SHALL hold its last value outside updates; partially written entries visible during FETCH are don't-care to consumer.
REQ-025 Minimum refill latency: rom_re high in IDLE at edge N -> rom_oe high in cycle N+1+2**LINE_WORDS_LOG2 with zero-wait acks.

Reset
REQ-026 While reset=1: state IDLE, counter 0, line_base 0, mem_rd=0, mem_addr=0, rom_oe=0, busy=0, all rom_out words 0.
REQ-027 Reset asserted mid-FETCH SHALL abort immediately; no rom_oe pulse for the aborted line; a pending mem_ack after release is ignored.
REQ-028 First request after reset release SHALL be accepted in the first clock edge with reset=0 and rom_re=1.

Verification
REQ-029 rom_addr=8000_0014, rom_re=1, mem_ack=1 every cycle, default params -> mem_addr 4,5,6,7 on consecutive cycles; rom_oe one cycle later with rom_out={w4,w5,w6,w7}; busy low two cycles after rom_oe.
REQ-030 Same request, mem_ack delayed 3 cycles per word -> mem_addr held stable each wait; rom_oe after 16 FETCH cycles; data order unchanged.
REQ-031 rom_re held high through DONE and COOL -> exactly one rom_oe pulse; new refill starts only after COOL.
REQ-032 rom_addr changed to 8000_0100 during FETCH -> fetched words remain 4..7; rom_out reflects original line.
REQ-033 reset pulsed after second ack -> mem_rd=0, rom_oe=0, rom_out all 0 asynchronously; no rom_oe until new request completes.
REQ-034 LINE_WORDS_LOG2=0, rom_addr=8000_0008 -> single request mem_addr=2; rom_oe two cycles after request accepted.
